alu4_result_buf: RTL
====================

ALU4_RESULT_BUF -- requirements
Module: alu4_result_buf

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: result FIFO entries; power of two, 2..16.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1: upstream 4-bit logic stage (NAND slice array) presents a result.
REQ-005 The block SHALL have port in_ready, output, 1: buffer can accept a result this cycle.
REQ-006 The block SHALL have port in_res, input, 4: result bits, bit i taken from slice i (na0..na3).
REQ-007 The block SHALL have port in_op, input, 2: operation tag carried with the result.
REQ-008 The block SHALL have port out_valid, output, 1: head entry available.
REQ-009 The block SHALL have port out_ready, input, 1: consumer takes the head entry.
REQ-010 The block SHALL have ports out_res (output, 4) and out_op (output, 2): head entry result and tag.
REQ-011 The block SHALL have ports out_zero (output, 1) and out_ones (output, 1): out_res==4'h0 and out_res==4'hF.
REQ-012 The block SHALL have port count, output, clog2(DEPTH)+1: current occupancy.
REQ-013 The block SHALL have port proto_err, output, 1: sticky protocol-violation flag.

Function
REQ-014 A push SHALL occur on a clk edge where in_valid=1 and in_ready=1, storing {in_op, in_res} at the write pointer.
REQ-015 A pop SHALL occur on a clk edge where out_valid=1 and out_ready=1, advancing the read pointer.
REQ-016 in_ready SHALL equal (count < DEPTH), registered-state-only, independent of out_ready in the same cycle.
REQ-017 out_valid SHALL equal (count != 0); out_res, out_op, out_zero and out_ones SHALL reflect the head entry and be don't-care-free (0) when empty.
REQ-018 Latency SHALL be one cycle: a result pushed at edge N is visible on out_* after edge N when the buffer was empty.
REQ-019 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order, including at count==1.
REQ-020 When full, a pop with in_valid=1 SHALL NOT push in that cycle; the push completes on a later edge where in_ready=1.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH with no entry loss or duplication.
REQ-022 proto_err SHALL set on any edge where in_valid=1 and in_ready=0, or where out_ready=1 and out_valid=0, and SHALL remain 1 until reset.
REQ-023 Upstream in_res/in_op SHALL be sampled only on push edges; values on non-push edges SHALL have no effect.

Reset
REQ-024 While rst=1, count, pointers and proto_err SHALL be 0, out_valid=0, in_ready=1, out_res=0, out_op=0, out_zero=1, out_ones=0, immediately and independent of clk.
REQ-025 Reset asserted mid-operation SHALL discard all stored entries; no pop or push SHALL occur on an edge while rst=1.

Configuration
REQ-026 With macro ALU4_PARITY_EN defined, the block SHALL store an even-parity bit per entry computed from in_res at push and expose it on extra port out_par (output, 1), 0 when empty or in reset.
REQ-027 Without ALU4_PARITY_EN, port out_par and the parity storage SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-028 Reset then push in_res=4'hA, in_op=2'd1, out_ready=0 -> next cycle out_valid=1, out_res=4'hA, out_op=1, count=1, out_zero=0.
REQ-029 Push 4'h0, 4'hF, 4'h5, 4'h3 with out_ready=0 -> count=4, in_ready=0; then pop 4 -> outputs 0/F/5/3 in order, out_zero=1 first, out_ones=1 second.
REQ-030 Full buffer, in_valid=1 and out_ready=1 same cycle -> one pop, no push, count=3, proto_err=1.
REQ-031 Continuous push/pop with count=1 for 10 cycles (values 0..9) -> outputs 0..9 in order, count stays 1, pointers wrap twice, proto_err=0.
REQ-032 count=3, assert rst for half a cycle between edges -> count=0, out_valid=0, proto_err=0 immediately; next push of 4'h7 appears alone.
REQ-033 ALU4_PARITY_EN defined, push 4'h7 then 4'h3 -> out_par=1 then 0.

Source files
------------

// File: rtl/alu4_result_buf.sv
// Result FIFO behind the 4-bit NAND-slice logic stage: buffers {op, result}
// with valid/ready handshakes on both sides. Optional macro: ALU4_PARITY_EN.
module alu4_result_buf #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_res,
  input  logic [1:0]                 in_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 out_res,
  output logic [1:0]                 out_op,
  output logic                       out_zero,
  output logic                       out_ones,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       proto_err
`ifdef ALU4_PARITY_EN
  ,
  output logic                       out_par
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
`ifdef ALU4_PARITY_EN
    logic       par;
`endif
    logic [1:0] op;
    logic [3:0] res;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             wr_entry;
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               proto_err_q, proto_err_d;
  logic               push, pop;

  // Handshake qualifiers derive from registered state only, so in_ready
  // never depends on out_ready combinationally.
  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !rst;
  assign pop       = out_valid && out_ready && !rst;

  always_comb begin
    wr_entry     = '0;
    wr_entry.res = in_res;
    wr_entry.op  = in_op;
`ifdef ALU4_PARITY_EN
    wr_entry.par = ^in_res;
`endif
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    proto_err_d = proto_err_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if ((in_valid && !in_ready) || (out_ready && !out_valid)) proto_err_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      proto_err_q <= proto_err_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; the outputs are masked
  // by out_valid, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_entry;
  end

  assign head      = mem[rd_ptr_q];
  assign out_res   = out_valid ? head.res : 4'h0;
  assign out_op    = out_valid ? head.op  : 2'd0;
  assign out_zero  = (out_res == 4'h0);
  assign out_ones  = (out_res == 4'hF);
  assign count     = count_q;
  assign proto_err = proto_err_q;
`ifdef ALU4_PARITY_EN
  assign out_par   = out_valid ? head.par : 1'b0;
`endif

endmodule
